data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a CPU-side master and the data memory responder.
// One request and one response channel, each with a valid/ready handshake.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accepts one load/store, waits LATENCY
// cycles, then holds a registered response until the CPU side takes it.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_access;
  logic          w_mem_we;

  // Decode of the latched request: word index, error flag and the access edge
  always_comb begin
    w_idx    = r_addr[AW+1:2];
    w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:AW+2] != {(30-AW){1'b0}});
    w_access = (r_state == WAIT) && (r_cnt == {CW{1'b0}});
    w_mem_we = w_access && r_write && !w_err && !reset;
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= {CW{1'b0}};
      r_write      <= 1'b0;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0000_0000;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_write     <= bus.req_write;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_cnt       <= CNT_INIT;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            // Stores and faulting requests return zero data
            r_resp_rdata <= (w_err || r_write) ? 32'h0000_0000 : r_mem[w_idx];
            r_resp_err   <= w_err;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_cnt        <= {CW{1'b0}};
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'h0000_0000;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance share the stimulus;
// sel picks which one is under test while the other is held in reset.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1, sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  int          lat;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  typedef struct {logic w; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err;} vec_t;
  exp_t sb_q[$];
  vec_t tbl1[13];
  vec_t tbl2[5];

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  assign bus0.req_valid  = req_valid;
  assign bus0.req_write  = req_write;
  assign bus0.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus0.resp_ready = resp_ready;
  assign bus1.req_valid  = req_valid;
  assign bus1.req_write  = req_write;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.resp_ready = resp_ready;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (.clk(clk), .reset(reset0), .bus(bus0));
  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset1), .bus(bus1));

  assign o_ready = sel ? bus1.req_ready  : bus0.req_ready;
  assign o_valid = sel ? bus1.resp_valid : bus0.resp_valid;
  assign o_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
  assign o_err   = sel ? bus1.resp_err   : bus0.resp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (o_ready !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("ready_before_accept", 32'(o_ready), 32'd1);
  endtask

  // Returns edges counted from the accept edge until resp_valid is seen
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_rdata"}, o_rdata, e.rdata);
      chk({tag, "_err"}, 32'(o_err), 32'(e.err));
    end
  endtask

  task automatic do_txn(input vec_t v);
    int   cyc;
    exp_t e;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = v.w; req_addr = v.addr; req_wdata = v.wdata;
    wait_ready();
    e.rdata = v.rdata; e.err = v.err;
    sb_q.push_back(e);
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_write = 1'($urandom_range(0, 1));
    chk("ready_low_after_accept", 32'(o_ready), 32'd0);
    wait_valid(cyc);
    chk("latency", 32'(cyc), 32'(lat));
    pop_check("txn");
    tick();
    chk("one_cycle_resp", 32'(o_valid), 32'd0);
    chk("ready_after_resp", 32'(o_ready), 32'd1);
  endtask

  initial begin
    int   cyc;
    exp_t e;
    tbl1[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl1[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl1[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl1[3]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b0};
    tbl1[4]  = '{1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl1[5]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl1[6]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl1[7]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    tbl1[8]  = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    tbl1[9]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl1[10] = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0000_0000, 1'b0};
    tbl1[11] = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl1[12] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    tbl2[0]  = '{1'b1, 32'h0000_0008, 32'h0102_0304, 32'h0000_0000, 1'b0};
    tbl2[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0102_0304, 1'b0};
    tbl2[2]  = '{1'b1, 32'h0000_000C, 32'h55AA_55AA, 32'h0000_0000, 1'b0};
    tbl2[3]  = '{1'b0, 32'h0000_000C, 32'h0000_0000, 32'h55AA_55AA, 1'b0};
    tbl2[4]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0102_0304, 1'b0};

    // Reset with a request presented: reset must win over the accept
    sel = 1'b0; lat = 2; reset0 = 1'b1; reset1 = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_wdata = 32'h0000_0000;
    repeat (2) tick();
    reset0 = 1'b0; req_valid = 1'b0;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_rdata", o_rdata, 32'h0000_0000);
    chk("rst_err", 32'(o_err), 32'd0);

    for (int i = 0; i < 13; i++) do_txn(tbl1[i]);

    // Backpressure: response held with a competing request pending
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    wait_ready();
    e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; sb_q.push_back(e);
    tick();
    req_addr = 32'h0000_03FC;
    wait_valid(cyc);
    chk("bp_latency", 32'(cyc), 32'd2);
    pop_check("bp");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_rdata", o_rdata, 32'hDEAD_BEEF);
      chk("hold_err", 32'(o_err), 32'd0);
      chk("hold_no_accept", 32'(o_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_valid", 32'(o_valid), 32'd0);
    chk("bp_idle_ready", 32'(o_ready), 32'd1);
    e.rdata = 32'hA5A5_A5A5; e.err = 1'b0; sb_q.push_back(e);
    tick();
    req_valid = 1'b0;
    chk("bp_next_accept", 32'(o_ready), 32'd0);
    wait_valid(cyc);
    chk("bp_next_latency", 32'(cyc), 32'd2);
    pop_check("bp_next");
    tick();

    // Reset on the WAIT->RESP edge abandons the store
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h2222_2222;
    wait_ready();
    tick();
    req_valid = 1'b0;
    tick();
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_rst_no_valid", 32'(o_valid), 32'd0);
      tick();
    end
    chk("wait_rst_ready", 32'(o_ready), 32'd1);
    do_txn('{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1111_1111, 1'b0});

    // Reset in RESP drops the response, even with resp_ready high
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
    wait_ready();
    tick();
    req_valid = 1'b0;
    wait_valid(cyc);
    chk("resp_rst_pre_rdata", o_rdata, 32'hDEAD_BEEF);
    reset0 = 1'b1; resp_ready = 1'b1;
    tick();
    reset0 = 1'b0;
    chk("resp_rst_valid", 32'(o_valid), 32'd0);
    chk("resp_rst_rdata", o_rdata, 32'h0000_0000);
    chk("resp_rst_err", 32'(o_err), 32'd0);
    chk("resp_rst_ready", 32'(o_ready), 32'd1);

    // Second phase: LATENCY=1 instance
    reset0 = 1'b1; reset1 = 1'b1;
    tick();
    sel = 1'b1; lat = 1; reset1 = 1'b0;
    chk("l1_rst_ready", 32'(o_ready), 32'd1);
    for (int i = 0; i < 5; i++) do_txn(tbl2[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
